// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its environment:
// instruction memory, execute-stage redirect, and the decode handshake.
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        input  fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction ROM, resolves
// direct jumps locally, takes execute redirects and hands words to decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_fetch_if.master   bus
);
    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    localparam logic [5:0] OP_JUMP = 6'b000010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic        advance;
    logic        handshake;
    logic        unused_target_lsbs;

    assign unused_target_lsbs = ^bus.redirect_target[1:0];

    always_comb begin
        state_d       = RUN;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;

        pc_plus4  = pc_q + 32'd4;
        advance   = (state_q == RUN) && (!out_valid_q || bus.out_ready);
        handshake = out_valid_q && bus.out_ready;

        // A consumed word still counts when a redirect flushes in the same cycle.
        fetch_count_d = fetch_count_q + {31'd0, handshake};

        if (bus.redirect_valid) begin
            pc_d        = {bus.redirect_target[31:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_instr_d = bus.imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            if (bus.imem_data[31:26] == OP_JUMP) begin
                pc_d = {pc_plus4[31:28], bus.imem_data[25:0], 2'b00};
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, corner
// sequences, and a randomized run against a stream-level reference model.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch_if bus2 ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Test program: word at 0x30 is "j 7" (target 0x1C); all other words are non-jumps.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h30) return {6'b000010, 26'd7};
        return {6'b001000, a[27:2]};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        logic [31:0] w;
        logic [31:0] p4;
        w  = rom_word(p);
        p4 = p + 32'd4;
        if (w[31:26] == 6'b000010) return {p4[31:28], w[25:0], 2'b00};
        return p4;
    endfunction

    assign bus.imem_data  = rom_word(bus.imem_addr);
    assign bus2.imem_data = rom_word(bus2.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p,
                                input logic [31:0] a, input logic [31:0] c);
        vec_t t;
        t.ready = r; t.valid = v; t.pc = p; t.addr = a; t.cnt = c;
        return t;
    endfunction

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] c);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, bus.out_pc, p);
            chk({tag, "_instr"}, bus.out_instr, rom_word(p));
        end
        chk({tag, "_addr"}, bus.imem_addr, a);
        chk({tag, "_count"}, bus.fetch_count, c);
    endtask

    initial begin
        logic [31:0] exp_head;
        logic [31:0] model_cnt;
        logic        expect_flush;
        logic        rdy;
        logic        rdr;
        logic [31:0] tgt;

        // Rows: ready input for the cycle, then expected outputs after its edge.
        vecs[0]  = mk(1'b1, 1'b0, 32'h00, 32'h00, 0);
        vecs[1]  = mk(1'b1, 1'b1, 32'h00, 32'h04, 0);
        vecs[2]  = mk(1'b1, 1'b1, 32'h04, 32'h08, 1);
        vecs[3]  = mk(1'b1, 1'b1, 32'h08, 32'h0C, 2);
        vecs[4]  = mk(1'b0, 1'b1, 32'h08, 32'h0C, 2);
        vecs[5]  = mk(1'b0, 1'b1, 32'h08, 32'h0C, 2);
        vecs[6]  = mk(1'b0, 1'b1, 32'h08, 32'h0C, 2);
        vecs[7]  = mk(1'b1, 1'b1, 32'h0C, 32'h10, 3);
        vecs[8]  = mk(1'b1, 1'b1, 32'h10, 32'h14, 4);
        vecs[9]  = mk(1'b1, 1'b1, 32'h14, 32'h18, 5);
        vecs[10] = mk(1'b1, 1'b1, 32'h18, 32'h1C, 6);
        vecs[11] = mk(1'b1, 1'b1, 32'h1C, 32'h20, 7);
        vecs[12] = mk(1'b1, 1'b1, 32'h20, 32'h24, 8);
        vecs[13] = mk(1'b1, 1'b1, 32'h24, 32'h28, 9);
        vecs[14] = mk(1'b1, 1'b1, 32'h28, 32'h2C, 10);
        vecs[15] = mk(1'b1, 1'b1, 32'h2C, 32'h30, 11);
        vecs[16] = mk(1'b1, 1'b1, 32'h30, 32'h1C, 12);
        vecs[17] = mk(1'b1, 1'b1, 32'h1C, 32'h20, 13);
        vecs[18] = mk(1'b1, 1'b1, 32'h20, 32'h24, 14);

        bus.out_ready        = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_target  = '0;
        bus2.out_ready       = 1'b1;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_target = '0;

        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_count", bus.fetch_count, 32'd0);
        chk("wrap_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        for (int n = 0; n < 19; n++) begin
            bus.out_ready = vecs[n].ready;
            step();
            chk_out($sformatf("vec%0d", n), vecs[n].valid, vecs[n].pc, vecs[n].addr, vecs[n].cnt);
            if (n == 0) chk("vec0_instr_zero", bus.out_instr, 32'd0);
            if (n == 1) begin
                chk("wrap_first_pc", bus2.out_pc, 32'hFFFF_FFFC);
                chk("wrap_addr", bus2.imem_addr, 32'd0);
            end
            if (n == 2) begin
                chk("wrap_next_pc", bus2.out_pc, 32'd0);
                chk("wrap_next_valid", {31'd0, bus2.out_valid}, 32'd1);
            end
        end

        // Redirect flushes a stalled instruction.
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h24;
        step();
        chk_out("flush", 1'b0, 32'h0, 32'h24, 14);
        bus.redirect_valid = 1'b0;
        step();
        chk_out("flush_tgt", 1'b1, 32'h24, 32'h28, 14);
        bus.out_ready = 1'b1;
        step();
        chk_out("pre_j0", 1'b1, 32'h28, 32'h2C, 15);
        step();
        chk_out("pre_j1", 1'b1, 32'h2C, 32'h30, 16);

        // Redirect in the cycle the jump word is on imem_data wins; handshake still counts.
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h10;
        step();
        chk_out("redir_jump", 1'b0, 32'h0, 32'h10, 17);
        bus.redirect_target = 32'h13;
        step();
        chk_out("redir_misalign", 1'b0, 32'h0, 32'h10, 17);
        bus.redirect_valid = 1'b0;
        step();
        chk_out("redir_tgt", 1'b1, 32'h10, 32'h14, 17);

        // Reset mid-stream overrides redirect and handshake.
        rst_n = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h40;
        step();
        chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_instr", bus.out_instr, 32'd0);
        chk("mrst_pc", bus.out_pc, 32'd0);
        chk("mrst_addr", bus.imem_addr, 32'd0);
        chk("mrst_count", bus.fetch_count, 32'd0);
        chk("mrst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("mrst_wrap_valid", {31'd0, bus2.out_valid}, 32'd0);
        bus.redirect_valid = 1'b0;

        // Randomized run: model tracks which PC should be presented next.
        rst_n = 1'b1;
        exp_head = 32'h0;
        model_cnt = 32'h0;
        expect_flush = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (expect_flush) chk("rnd_flush", {31'd0, bus.out_valid}, 32'd0);
            chk("rnd_count", bus.fetch_count, model_cnt);
            if (bus.out_valid) begin
                chk("rnd_pc", bus.out_pc, exp_head);
                chk("rnd_instr", bus.out_instr, rom_word(exp_head));
                chk("rnd_addr", bus.imem_addr, next_pc(exp_head));
            end else begin
                chk("rnd_addr_idle", bus.imem_addr, exp_head);
            end

            rdy = ($urandom_range(3) != 0);
            rdr = ($urandom_range(15) == 0);
            tgt = $urandom_range(32'h5F);
            bus.out_ready       = rdy;
            bus.redirect_valid  = rdr;
            bus.redirect_target = tgt;

            if (bus.out_valid && rdy) begin
                model_cnt = model_cnt + 1;
                exp_head  = next_pc(exp_head);
            end
            if (rdr) exp_head = {tgt[31:2], 2'b00};
            expect_flush = rdr;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage on the initiator side of the instruction-memory interface.
- Owns the program counter, drives the 32-bit byte address to the combinational instruction ROM and captures the returned 32-bit word.
- Resolves direct jumps (opcode 000010) locally and accepts branch redirects from execute.
- Presents each instruction with its PC to decode over a valid/ready handshake.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  synchronous, active-low reset
- imem_addr  output  32  byte address to instruction memory; equals the PC register
- imem_data  input  32  instruction word for imem_addr, valid in the same cycle (combinational memory)
- redirect_valid  input  1  execute-stage redirect (taken branch); single-cycle pulse
- redirect_target  input  32  new PC when redirect_valid=1
- out_valid  output  1  out_instr/out_pc hold a valid instruction
- out_instr  output  32  captured instruction word
- out_pc  output  32  address out_instr was fetched from
- out_ready  input  1  decode accepts the instruction this cycle
- fetch_count  output  32  number of instructions handed to decode; wraps at 2^32

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle; no capture; PC holds RESET_PC.
  - RUN: normal fetch.
- Transitions: BOOT -> RUN unconditionally. rst_n=0 returns to BOOT from any state.
- Reset values: pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0, state=BOOT.
- imem_addr = pc at all times, including BOOT.
- advance = (state==RUN) && (!out_valid || out_ready).
- Priority per cycle, highest first:
  1. redirect_valid=1 (any state): pc <= {redirect_target[31:2],2'b00}; out_valid <= 0 (flush, even if out_ready=0); no capture; state <= RUN.
  2. advance: out_instr <= imem_data; out_pc <= pc; out_valid <= 1. If imem_data[31:26]==6'b000010, pc <= {pc_plus4[31:28], imem_data[25:0], 2'b00}; otherwise pc <= pc+4.
  3. Otherwise (stall, or BOOT): pc and output registers hold.
- pc_plus4 = pc+4, computed modulo 2^32; 32'hFFFFFFFC wraps to 0.
- Jumps have no delay slot. The jump word itself is delivered to decode. The next delivered instruction is the jump target.
- Branches are not decoded here; execute must pulse redirect_valid for them.
- A handshake completes when out_valid && out_ready. At that point fetch_count increments. A handshake in the same cycle as a redirect still counts, because the instruction was consumed before the flush.
- Outputs are register-driven only; no combinational path from out_ready to out_valid.

## Timing
- Fetch latency: word at PC X appears on out_instr one cycle after imem_addr=X.
- Throughput: one instruction per cycle with out_ready held 1.
- First valid output: reset deasserted at edge E0 -> BOOT cycle -> capture at edge E2 -> out_valid=1 after E2, with out_pc=RESET_PC.
- Stall: out_valid=1 with out_ready=0 freezes pc, out_instr and out_pc. The next word is captured on the edge where out_ready=1.
- Redirect penalty: out_valid=0 for the cycle after the redirect edge. The target instruction is valid one cycle later.
- rst_n=0 mid-stream: all registers return to reset values at the next edge, regardless of redirect or handshake inputs.

## Test plan
- Sequential fetch and local jump: reset, out_ready=1, ROM holding the standard 13-word test program (jump at 0x30, index 7) -> out_pc sequence 0x00,0x04,...,0x30,0x1C,0x20,...; out_valid low for exactly 2 cycles after reset release.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x08 -> out_pc/out_instr stable, imem_addr stays 0x0C, fetch_count unchanged; the next handshake delivers out_pc=0x0C.
- Redirect flush: redirect_valid with target 0x24 while out_valid=1, out_ready=0 -> out_valid=0 next cycle, imem_addr=0x24, then out_pc=0x24.
- Redirect beats jump: redirect to 0x10 in the same cycle the jump at 0x30 is fetched -> pc=0x10, jump not captured. A misaligned target 0x13 yields pc=0x10.
- Wrap and reset: RESET_PC=32'hFFFFFFFC with a non-jump word -> next out_pc=0x0. Assert rst_n=0 mid-stream -> all outputs zero and pc=RESET_PC on the following edge.
